// File: rtl/timer_pkg.sv
// -----------------------------------------------------------------------------
// timer_pkg
// Shared types and constants for the countdown timer slice.
//   state_t  : controller state encoding (SETUP, IDLE, RUN, PAUSE, DONE)
//   TIME_W   : width of the minute / second fields
//   SEC_MAX  : highest seconds value, reloaded on a minute borrow
//   MIN_MAX  : highest minutes value
// -----------------------------------------------------------------------------
package timer_pkg;

    localparam int TIME_W  = 6;
    localparam int SEC_MAX = 59;
    localparam int MIN_MAX = 59;

    typedef enum logic [2:0] {
        SETUP = 3'd0,
        IDLE  = 3'd1,
        RUN   = 3'd2,
        PAUSE = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/tick_gen.sv
// -----------------------------------------------------------------------------
// tick_gen
// Free-running period counter. Counts 0..TICK_CYCLES-1 while en is high and
// is forced back to 0 whenever en is low, so every enable starts a fresh,
// full-length period.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   en    : count enable; low clears the counter on the next edge
//   tick  : high during the last cycle of each period (counter at maximum)
// -----------------------------------------------------------------------------
module tick_gen #(
    parameter int TICK_CYCLES = 100_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_CYCLES - 1);

    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (!en || cnt_reg == CNT_MAX) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign tick = (cnt_reg == CNT_MAX);

endmodule

// File: rtl/countdown_timer.sv
// -----------------------------------------------------------------------------
// countdown_timer
// Counts a minute/second preset down to 00:00 at one decrement per tick, with
// start/pause/resume/rearm from a single one-cycle button pulse.
//   clk         : system clock
//   rst_n       : asynchronous active-low reset
//   mode        : 1 = track preset (SETUP), 0 = run controls
//   start_pulse : start / pause / resume / rearm
//   min_init    : preset minutes
//   sec_init    : preset seconds
//   min_cnt     : current minutes
//   sec_cnt     : current seconds
//   running     : high while in RUN
//   done        : high while in DONE
//   done_blink  : display blank strobe for the DONE indication
// Build option: COUNTDOWN_TIMER_BLINK_EN makes done_blink toggle every
// HALF_CYCLES cycles while in DONE; otherwise done_blink simply follows done.
// -----------------------------------------------------------------------------
module countdown_timer
    import timer_pkg::*;
#(
    parameter int TICK_CYCLES = 100_000_000,
    parameter int HALF_CYCLES = TICK_CYCLES / 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mode,
    input  logic              start_pulse,
    input  logic [TIME_W-1:0] min_init,
    input  logic [TIME_W-1:0] sec_init,
    output logic [TIME_W-1:0] min_cnt,
    output logic [TIME_W-1:0] sec_cnt,
    output logic              running,
    output logic              done,
    output logic              done_blink
);

    state_t            state_reg, state_next;
    logic [TIME_W-1:0] min_reg, min_next;
    logic [TIME_W-1:0] sec_reg, sec_next;
    logic              running_reg;
    logic              done_reg;
    logic              tick;
    logic              tick_en;

    // The period counter runs only while we stay in RUN; any exit (pause,
    // done, setup) clears it so a later resume waits a full period.
    assign tick_en = (state_reg == RUN) && (state_next == RUN);

    tick_gen #(
        .TICK_CYCLES(TICK_CYCLES)
    ) u_tick_gen (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (tick_en),
        .tick (tick)
    );

    always_comb begin
        state_next = state_reg;
        min_next   = min_reg;
        sec_next   = sec_reg;
        if (mode) begin
            state_next = SETUP;
            min_next   = min_init;
            sec_next   = sec_init;
        end else begin
            case (state_reg)
                SETUP: state_next = IDLE;
                IDLE: begin
                    if (start_pulse) begin
                        state_next = (min_reg == '0 && sec_reg == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    // A pause coinciding with a tick discards the tick.
                    if (start_pulse) begin
                        state_next = PAUSE;
                    end else if (tick) begin
                        if (sec_reg != '0) begin
                            sec_next = sec_reg - 1'b1;
                        end else begin
                            sec_next = TIME_W'(SEC_MAX);
                            min_next = min_reg - 1'b1;
                        end
                        if (min_next == '0 && sec_next == '0) begin
                            state_next = DONE;
                        end
                    end
                end
                PAUSE: begin
                    if (start_pulse) begin
                        state_next = RUN;
                    end
                end
                DONE: begin
                    if (start_pulse) begin
                        state_next = IDLE;
                        min_next   = min_init;
                        sec_next   = sec_init;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            min_reg     <= '0;
            sec_reg     <= '0;
            running_reg <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            min_reg     <= min_next;
            sec_reg     <= sec_next;
            running_reg <= (state_next == RUN);
            done_reg    <= (state_next == DONE);
        end
    end

    assign min_cnt = min_reg;
    assign sec_cnt = sec_reg;
    assign running = running_reg;
    assign done    = done_reg;

`ifdef COUNTDOWN_TIMER_BLINK_EN
    logic blink_reg;
    logic half_tick;
    logic half_en;

    assign half_en = (state_reg == DONE) && (state_next == DONE);

    tick_gen #(
        .TICK_CYCLES(HALF_CYCLES)
    ) u_blink_gen (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (half_en),
        .tick (half_tick)
    );

    // Starts lit on DONE entry, flips at the end of every half period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_reg <= 1'b0;
        end else if (state_next != DONE) begin
            blink_reg <= 1'b0;
        end else if (state_reg != DONE) begin
            blink_reg <= 1'b1;
        end else if (half_tick) begin
            blink_reg <= ~blink_reg;
        end
    end

    assign done_blink = blink_reg;
`else
    assign done_blink = done_reg;
`endif

endmodule

// File: tb/tb_countdown_timer.sv
module tb_countdown_timer;

    localparam int TICK = 4;
    localparam int HALF = 2;

    localparam int M_SETUP = 0;
    localparam int M_IDLE  = 1;
    localparam int M_RUN   = 2;
    localparam int M_PAUSE = 3;
    localparam int M_DONE  = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       mode = 1'b0;
    logic       start_pulse = 1'b0;
    logic [5:0] min_init = '0;
    logic [5:0] sec_init = '0;
    logic [5:0] min_cnt;
    logic [5:0] sec_cnt;
    logic       running;
    logic       done;
    logic       done_blink;

    int checks = 0;
    int errors = 0;

    // Behavioural model: time kept as total seconds, run progress as cycles
    // elapsed in the current one-second period, blink as cycles since DONE.
    int m_st    = M_IDLE;
    int m_total = 0;
    int m_ph    = 0;
    int m_age   = 0;

    countdown_timer #(
        .TICK_CYCLES(TICK),
        .HALF_CYCLES(HALF)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mode       (mode),
        .start_pulse(start_pulse),
        .min_init   (min_init),
        .sec_init   (sec_init),
        .min_cnt    (min_cnt),
        .sec_cnt    (sec_cnt),
        .running    (running),
        .done       (done),
        .done_blink (done_blink)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_st = M_IDLE; m_total = 0; m_ph = 0; m_age = 0;
        end else if (mode) begin
            m_st = M_SETUP; m_total = min_init * 60 + sec_init; m_ph = 0;
        end else begin
            case (m_st)
                M_SETUP: m_st = M_IDLE;
                M_IDLE: if (start_pulse) begin
                    m_st = (m_total == 0) ? M_DONE : M_RUN;
                    m_ph = 0; m_age = 0;
                end
                M_RUN: if (start_pulse) begin
                    m_st = M_PAUSE;
                end else begin
                    m_ph++;
                    if (m_ph == TICK) begin
                        m_ph = 0;
                        m_total--;
                        if (m_total == 0) begin
                            m_st = M_DONE; m_age = 0;
                        end
                    end
                end
                M_PAUSE: if (start_pulse) begin
                    m_st = M_RUN; m_ph = 0;
                end
                M_DONE: if (start_pulse) begin
                    m_st = M_IDLE; m_total = min_init * 60 + sec_init;
                end else begin
                    m_age++;
                end
                default: m_st = M_IDLE;
            endcase
        end
    end

    function automatic int exp_blink();
`ifdef COUNTDOWN_TIMER_BLINK_EN
        return (m_st == M_DONE && ((m_age / HALF) % 2) == 0) ? 1 : 0;
`else
        return (m_st == M_DONE) ? 1 : 0;
`endif
    endfunction

    task automatic check(input string name, input int got, input int expv);
        checks++;
        if (got != expv) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d at %0t", name, got, expv, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        check("model_min", int'(min_cnt), m_total / 60);
        check("model_sec", int'(sec_cnt), m_total % 60);
        check("model_running", int'(running), (m_st == M_RUN) ? 1 : 0);
        check("model_done", int'(done), (m_st == M_DONE) ? 1 : 0);
        check("model_blink", int'(done_blink), exp_blink());
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse();
        start_pulse = 1'b1;
        @(negedge clk);
        start_pulse = 1'b0;
    endtask

    task automatic preset(input int m, input int s);
        mode = 1'b1; min_init = 6'(m); sec_init = 6'(s);
        @(negedge clk);
        mode = 1'b0;
        @(negedge clk);
        $display("preset %0d:%0d loaded -> %0d:%0d", m, s, min_cnt, sec_cnt);
    endtask

    task automatic time_is(input string name, input int m, input int s);
        check({name, "_min"}, int'(min_cnt), m);
        check({name, "_sec"}, int'(sec_cnt), s);
        $display("%s: %0d:%0d running=%0d done=%0d blink=%0d", name, min_cnt, sec_cnt,
                 running, done, done_blink);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int blink_seq [5];
        blink_seq = '{1, 1, 0, 0, 1};

        cyc(2);
        rst_n = 1'b1;
        time_is("reset", 0, 0);
        check("reset_running", int'(running), 0);
        check("reset_done", int'(done), 0);

        // Setup 01:00, start ignored while mode=1.
        mode = 1'b1; min_init = 6'd1; sec_init = 6'd0; start_pulse = 1'b1;
        @(negedge clk);
        start_pulse = 1'b0;
        time_is("setup_track", 1, 0);
        check("setup_start_ignored", int'(running), 0);
        mode = 1'b0;
        cyc(1);
        pulse();
        check("run_entry_running", int'(running), 1);
        cyc(3);
        time_is("before_borrow", 1, 0);
        cyc(1);
        time_is("borrow", 0, 59);
        check("borrow_running", int'(running), 1);

        // mode=1 mid-run: shadow preset, then count 00:02 to done.
        cyc(2);
        mode = 1'b1; min_init = 6'd0; sec_init = 6'd2;
        @(negedge clk);
        time_is("mode_in_run", 0, 2);
        check("mode_in_run_running", int'(running), 0);
        mode = 1'b0;
        cyc(1);
        pulse();
        cyc(4);
        time_is("count_1", 0, 1);
        cyc(4);
        time_is("count_0", 0, 0);
        check("done_entry_done", int'(done), 1);
        check("done_entry_running", int'(running), 0);
        for (int i = 0; i < 5; i++) begin
`ifdef COUNTDOWN_TIMER_BLINK_EN
            check("blink_seq", int'(done_blink), blink_seq[i]);
`else
            check("blink_steady", int'(done_blink), 1);
`endif
            cyc(1);
        end
        cyc(15);
        time_is("done_hold", 0, 0);
        check("done_hold_done", int'(done), 1);

        // Rearm from DONE with 00:07.
        min_init = 6'd0; sec_init = 6'd7;
        pulse();
        time_is("rearm", 0, 7);
        check("rearm_done", int'(done), 0);
        check("rearm_blink", int'(done_blink), 0);

        // Pause coincident with tick at 00:05.
        preset(0, 5);
        pulse();
        cyc(3);
        pulse();
        time_is("pause_on_tick", 0, 5);
        check("pause_running", int'(running), 0);
        cyc(10);
        time_is("pause_hold", 0, 5);
        pulse();
        cyc(3);
        time_is("resume_wait", 0, 5);
        cyc(1);
        time_is("resume_tick", 0, 4);

        // Asynchronous reset mid-run at 00:03.
        cyc(4);
        time_is("pre_reset", 0, 3);
        #2 rst_n = 1'b0;
        #1;
        time_is("async_reset", 0, 0);
        check("async_reset_running", int'(running), 0);
        check("async_reset_done", int'(done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1);
        pulse();
        check("zero_start_done", int'(done), 1);
        check("zero_start_running", int'(running), 0);
        cyc(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
